ysyx_25060173_ifu: RTL and testbench

//   Instruction fetch unit: the producer of the 32-bit instruction word consumed by the instruction decoder.

---
 rtl/ysyx_25060173_ifu_pkg.sv | 33 +++
 rtl/ysyx_25060173_ifu_if.sv | 40 ++++
 rtl/ysyx_25060173_reg.sv | 34 +++
 rtl/ysyx_25060173_ifu.sv | 206 ++++++++++++++++++++
 tb/tb_ysyx_25060173_ifu.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25060173_ifu_pkg.sv
// ============================================================================
// Module  : ysyx_25060173_ifu_pkg
// Purpose : Shared definitions for the instruction fetch unit: FSM state
//           encodings, reset PC default, instruction width and PC step.
// Config  : YSYX_25060173_IFU_ALIGN_CHK_EN adds the sticky FAULT state.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_25060173_ifu_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  // REQ  : request outstanding on the memory port
  // WAIT : request accepted, waiting for the single response
  // HOLD : instruction presented to the decoder
  // FAULT: misaligned redirect seen, fetch halted until reset
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
`ifdef YSYX_25060173_IFU_ALIGN_CHK_EN
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
`else
    S_HOLD  = 2'd2
`endif
  } ifu_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_25060173_ifu_if.sv
// ============================================================================
// Module  : ysyx_25060173_ifu_if
// Purpose : Bundles the fetch unit's memory request/response port, decoder
//           handshake, redirect input and fault flag.
// Modports: master - fetch unit side (drives request, instruction, fault)
//           slave  - environment side (memory, decoder, execute)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface ysyx_25060173_ifu_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, inst_ready,
           redirect_valid, redirect_pc
  );

endinterface

`default_nettype wire

// File: rtl/ysyx_25060173_reg.sv
// ============================================================================
// Module  : ysyx_25060173_reg
// Purpose : Width/reset-value parameterised D flip-flop with load enable and
//           synchronous active-high reset.
// Ports   : clk, rst        - clock, synchronous reset
//           i_en            - load enable
//           i_d  [WIDTH]    - next value
//           o_q  [WIDTH]    - registered value
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_25060173_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= RESET_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_25060173_ifu.sv
// ============================================================================
// Module  : ysyx_25060173_ifu
// Purpose : Instruction fetch unit. Holds the PC, issues one fetch at a time
//           to instruction memory and presents {inst, inst_pc} to decode.
//           Execute redirects override the PC; stale fetches are squashed.
// Ports   : clk, rst  - clock, synchronous active-high reset
//           bus       - ysyx_25060173_ifu_if.master (memory req/rsp,
//                       decoder handshake, redirect, fetch_fault)
// Params  : RESET_PC  - first fetch address after reset
// Config  : YSYX_25060173_IFU_ALIGN_CHK_EN - misaligned redirect enters a
//           sticky FAULT state; otherwise redirect_pc[1:0] is forced to 0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_25060173_ifu
  import ysyx_25060173_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_25060173_ifu_if.master        bus
);

  ifu_state_e          r_state;
  logic                r_drop;
  logic                r_req_valid;
  logic                r_inst_valid;
  logic [31:0]         r_pc;
  logic [INST_W-1:0]   r_inst;
  logic [31:0]         r_inst_pc;

  logic                w_hs;
  logic                w_rsp;
  logic                w_consume;
  logic                w_redir_ok;
  logic [31:0]         w_redir_tgt;
  logic                w_pc_en;
  logic [31:0]         w_pc_d;
  logic                w_latch;

`ifdef YSYX_25060173_IFU_ALIGN_CHK_EN
  logic                r_fault;
  logic                w_misalign;

  assign w_misalign  = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
  // Once faulted the PC is frozen; a misaligned target is never loaded.
  assign w_redir_ok  = bus.redirect_valid & ~w_misalign & (r_state != S_FAULT);
  assign w_redir_tgt = bus.redirect_pc;
`else
  logic                w_unused_lsb;

  assign w_redir_ok   = bus.redirect_valid;
  assign w_redir_tgt  = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused_lsb = ^bus.redirect_pc[1:0];
`endif

  // r_req_valid is only ever set while in REQ, so it qualifies the handshake.
  assign w_hs      = r_req_valid & bus.mem_req_ready;
  assign w_rsp     = (r_state == S_WAIT) & bus.mem_rsp_valid;
  assign w_consume = (r_state == S_HOLD) & bus.inst_ready;

  // Redirect wins over the sequential +4, including a same-cycle consume.
  assign w_pc_en = w_redir_ok | w_consume;
  assign w_pc_d  = w_redir_ok ? w_redir_tgt : (r_pc + PC_STEP);

  // A response is captured only when it belongs to the current PC stream.
  assign w_latch = w_rsp & ~r_drop & ~bus.redirect_valid;

  ysyx_25060173_reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_pc_en),
    .i_d  (w_pc_d),
    .o_q  (r_pc)
  );

  ysyx_25060173_reg #(.WIDTH(INST_W), .RESET_VAL('0)) u_inst_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_latch),
    .i_d  (bus.mem_rsp_rdata),
    .o_q  (r_inst)
  );

  ysyx_25060173_reg #(.WIDTH(32), .RESET_VAL(32'h0)) u_inst_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_latch),
    .i_d  (r_pc),
    .o_q  (r_inst_pc)
  );

  // Valid outputs are registered alongside the state: they are loaded with
  // the value matching the state being entered. Right after reset the FSM is
  // in REQ with the request valid still low, giving one idle cycle before the
  // first fetch is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_drop       <= 1'b0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
`ifdef YSYX_25060173_IFU_ALIGN_CHK_EN
      r_fault      <= 1'b0;
`endif
    end else begin
`ifdef YSYX_25060173_IFU_ALIGN_CHK_EN
      if (r_state == S_FAULT) begin
        // Sticky until reset; late responses and redirects are ignored.
      end else if (w_misalign) begin
        r_state      <= S_FAULT;
        r_drop       <= 1'b0;
        r_req_valid  <= 1'b0;
        r_inst_valid <= 1'b0;
        r_fault      <= 1'b1;
      end else
`endif
      if (bus.redirect_valid) begin
        case (r_state)
          S_REQ: begin
            if (w_hs) begin
              // The accepted fetch is for the old PC; squash its response.
              r_state     <= S_WAIT;
              r_drop      <= 1'b1;
              r_req_valid <= 1'b0;
            end else begin
              r_req_valid <= 1'b1;
            end
          end
          S_WAIT: begin
            if (bus.mem_rsp_valid) begin
              r_state     <= S_REQ;
              r_drop      <= 1'b0;
              r_req_valid <= 1'b1;
            end else begin
              r_drop      <= 1'b1;
            end
          end
          S_HOLD: begin
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
          end
          default: begin
            r_state      <= S_REQ;
            r_drop       <= 1'b0;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
          end
        endcase
      end else begin
        case (r_state)
          S_REQ: begin
            if (w_hs) begin
              r_state     <= S_WAIT;
              r_req_valid <= 1'b0;
            end else begin
              r_req_valid <= 1'b1;
            end
          end
          S_WAIT: begin
            if (bus.mem_rsp_valid) begin
              if (r_drop) begin
                r_state     <= S_REQ;
                r_drop      <= 1'b0;
                r_req_valid <= 1'b1;
              end else begin
                r_state      <= S_HOLD;
                r_inst_valid <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (bus.inst_ready) begin
              r_state      <= S_REQ;
              r_inst_valid <= 1'b0;
              r_req_valid  <= 1'b1;
            end
          end
          default: begin
            r_state      <= S_REQ;
            r_drop       <= 1'b0;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.mem_req_valid = r_req_valid;
  assign bus.mem_req_addr  = r_pc;
  assign bus.inst_valid    = r_inst_valid;
  assign bus.inst          = r_inst;
  assign bus.inst_pc       = r_inst_pc;
`ifdef YSYX_25060173_IFU_ALIGN_CHK_EN
  assign bus.fetch_fault   = r_fault;
`else
  assign bus.fetch_fault   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25060173_ifu.sv
// ============================================================================
// Module  : tb_ysyx_25060173_ifu
// Purpose : Self-checking bench for ysyx_25060173_ifu: directed scenarios
//           followed by a randomized run against an architectural PC model.
// Config  : YSYX_25060173_IFU_ALIGN_CHK_EN selects the fault expectations.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25060173_ifu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_25060173_ifu_if bus ();

  ysyx_25060173_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          nchecks = 0;
  int          nerrors = 0;

  // Memory model state: one outstanding request, response after a latency.
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          lat_min;
  int          lat_max;
  int          ready_mode;   // 0: always ready, 1: never ready, 2: random

  logic [31:0] exp_pc;
  int          nconsumed;
  bit          prev_req_pend;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    if (pend && pend_cnt == 0) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = mem_word(pend_addr);
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = $urandom;
      if (pend) pend_cnt--;
    end
    case (ready_mode)
      0:       bus.mem_req_ready = 1'b1;
      1:       bus.mem_req_ready = 1'b0;
      default: bus.mem_req_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Called at a negedge with this cycle's inputs settled; advances one cycle.
  task automatic tick();
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (bus.mem_rsp_valid) pend = 1'b0;
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        chk("one_outstanding", {31'b0, pend}, 32'd0);
        pend      = 1'b1;
        pend_addr = bus.mem_req_addr;
        pend_cnt  = $urandom_range(lat_min, lat_max);
      end
    end
    @(posedge clk);
    @(negedge clk);
    drive_mem();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_rdata  = 32'h0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    pend = 1'b0; pend_addr = 32'h0; pend_cnt = 0;
    lat_min = 0; lat_max = 0; ready_mode = 0;
    nconsumed = 0; prev_req_pend = 1'b0;

    @(negedge clk);
    drive_mem();
    tick();
    tick();

    // Reset state
    chk("rst_req_valid",  {31'b0, bus.mem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, bus.inst_valid},    32'd0);
    chk("rst_fault",      {31'b0, bus.fetch_fault},   32'd0);
    chk("rst_inst",       bus.inst,                   32'h0);
    chk("rst_inst_pc",    bus.inst_pc,                32'h0);
    chk("rst_addr",       bus.mem_req_addr,           32'h8000_0000);

    // First fetch, zero-wait memory, decoder always ready
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    chk("c0_req_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    tick();
    chk("c1_req_valid", {31'b0, bus.mem_req_valid}, 32'd1);
    chk("c1_addr",      bus.mem_req_addr,           32'h8000_0000);
    tick();
    chk("c2_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    chk("c3_inst_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("c3_inst",       bus.inst,                32'h0000_0413);
    chk("c3_inst_pc",    bus.inst_pc,             32'h8000_0000);
    tick();
    chk("c4_req_valid", {31'b0, bus.mem_req_valid}, 32'd1);
    chk("c4_addr",      bus.mem_req_addr,           32'h8000_0004);

    // Decoder stalls for 5 cycles in HOLD
    bus.inst_ready = 1'b0;
    tick();
    tick();
    chk("hold_inst_valid", {31'b0, bus.inst_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_inst_pc",  bus.inst_pc,                32'h8000_0004);
      chk("hold_inst",     bus.inst,                   mem_word(32'h8000_0004));
      chk("hold_no_req",   {31'b0, bus.mem_req_valid}, 32'd0);
      tick();
    end
    bus.inst_ready = 1'b1;
    tick();
    chk("hold_rel_req_valid", {31'b0, bus.mem_req_valid}, 32'd1);
    chk("hold_rel_addr",      bus.mem_req_addr,           32'h8000_0008);
    chk("hold_rel_inst_valid",{31'b0, bus.inst_valid},    32'd0);

    // Redirect in the same cycle as the request handshake
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    tick();
    bus.redirect_valid = 1'b0;
    chk("drop_inst_valid_a", {31'b0, bus.inst_valid},    32'd0);
    chk("drop_req_valid_a",  {31'b0, bus.mem_req_valid}, 32'd0);
    tick();
    chk("drop_inst_valid_b", {31'b0, bus.inst_valid},    32'd0);
    chk("drop_req_valid_b",  {31'b0, bus.mem_req_valid}, 32'd1);
    chk("drop_addr",         bus.mem_req_addr,           32'h8000_0100);

    // Redirect in HOLD with inst_ready in the same cycle
    tick();
    tick();
    chk("hredir_inst_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("hredir_inst_pc",    bus.inst_pc,             32'h8000_0100);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0040;
    tick();
    bus.redirect_valid = 1'b0;
    chk("hredir_req_valid",   {31'b0, bus.mem_req_valid}, 32'd1);
    chk("hredir_addr",        bus.mem_req_addr,           32'h8000_0040);
    chk("hredir_inst_valid2", {31'b0, bus.inst_valid},    32'd0);

    // Memory not ready for 4 cycles
    ready_mode = 1;
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_req_valid", {31'b0, bus.mem_req_valid}, 32'd1);
      chk("stall_addr",      bus.mem_req_addr,           32'h8000_0040);
    end

    // Accept with a slow response, then reset while waiting
    ready_mode = 0;
    bus.mem_req_ready = 1'b1;
    lat_min = 3; lat_max = 3;
    tick();
    chk("wait_req_valid",  {31'b0, bus.mem_req_valid}, 32'd0);
    chk("wait_inst_valid", {31'b0, bus.inst_valid},    32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lat_min = 0; lat_max = 0;
    chk("mrst_addr",       bus.mem_req_addr,           32'h8000_0000);
    chk("mrst_req_valid",  {31'b0, bus.mem_req_valid}, 32'd0);
    chk("mrst_inst_valid", {31'b0, bus.inst_valid},    32'd0);
    tick();
    chk("mrst_req_valid2", {31'b0, bus.mem_req_valid}, 32'd1);
    chk("mrst_addr2",      bus.mem_req_addr,           32'h8000_0000);

    // Misaligned redirect
    ready_mode = 1;
    bus.mem_req_ready  = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0102;
    tick();
    bus.redirect_valid = 1'b0;
`ifdef YSYX_25060173_IFU_ALIGN_CHK_EN
    ready_mode = 0;
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("fault_flag",       {31'b0, bus.fetch_fault},   32'd1);
      chk("fault_req_valid",  {31'b0, bus.mem_req_valid}, 32'd0);
      chk("fault_inst_valid", {31'b0, bus.inst_valid},    32'd0);
      bus.redirect_valid = (i == 1);
      bus.redirect_pc    = 32'h8000_0200;
      tick();
    end
    bus.redirect_valid = 1'b0;
`else
    chk("mis_addr",      bus.mem_req_addr,           32'h8000_0100);
    chk("mis_req_valid", {31'b0, bus.mem_req_valid}, 32'd1);
    chk("mis_fault",     {31'b0, bus.fetch_fault},   32'd0);
`endif

    // PC wrap at the top of the address space
    ready_mode = 0;
    bus.mem_req_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("wrap_fault_clear", {31'b0, bus.fetch_fault}, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    chk("wrap_addr", bus.mem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst",    bus.inst,    mem_word(32'hFFFF_FFFC));
    tick();
    chk("wrap_next_addr",  bus.mem_req_addr,           32'h0000_0000);
    chk("wrap_next_valid", {31'b0, bus.mem_req_valid}, 32'd1);

    // Randomized run against the architectural PC model
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_pc     = 32'h8000_0000;
    ready_mode = 2;
    lat_min    = 0;
    lat_max    = 2;
    prev_req_pend = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_req_pend)
        chk("rnd_req_hold", {31'b0, bus.mem_req_valid}, 32'd1);
      if (bus.mem_req_valid)
        chk("rnd_addr", bus.mem_req_addr, exp_pc);
      if (bus.inst_valid) begin
        chk("rnd_inst_pc", bus.inst_pc, exp_pc);
        chk("rnd_inst",    bus.inst,    mem_word(exp_pc));
      end
      bus.inst_ready     = 1'($urandom_range(0, 1));
      bus.redirect_valid = ($urandom_range(0, 15) == 0);
      bus.redirect_pc    = 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2);
      prev_req_pend = bus.mem_req_valid && !bus.mem_req_ready;
      if (bus.redirect_valid) begin
        exp_pc = bus.redirect_pc;
      end else if (bus.inst_valid && bus.inst_ready) begin
        exp_pc = exp_pc + 32'd4;
        nconsumed++;
      end
      tick();
    end
    bus.redirect_valid = 1'b0;
    chk("rnd_progress", {31'b0, (nconsumed >= 100)}, 32'd1);
    chk("rnd_fault",    {31'b0, bus.fetch_fault},    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

`default_nettype wire
